// File: rtl/ucode_prefetch.sv
// ucode_prefetch: microcode prefetch engine.
// Streams a program out of the UCODE SRAM into a small credit-controlled
// queue and hands instructions to decode over a valid/ready handshake.
// Optional stall/starve performance counters: define UCODE_PREFETCH_PERF_EN.

package isa_pkg;
  // Opcode byte (instruction bits [7:0]) that terminates a program
  localparam logic [7:0] OP_END = 8'hFF;
endpackage

module ucode_prefetch #(
  parameter int unsigned INSTR_W     = 128,
  parameter int unsigned SRAM_ADDR_W = 12,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic [SRAM_ADDR_W-1:0] ucode_base_addr,
  input  logic [SRAM_ADDR_W-1:0] ucode_len,
  output logic                   rd_en,
  output logic [SRAM_ADDR_W-1:0] rd_addr,
  input  logic [INSTR_W-1:0]     rd_data,
  input  logic                   rd_valid,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_W-1:0]     instr_data,
  output logic [SRAM_ADDR_W-1:0] pc,
  output logic                   done,
  output logic                   busy
`ifdef UCODE_PREFETCH_PERF_EN
  ,
  output logic [31:0]            perf_stall_cycles,
  output logic [31:0]            perf_starve_cycles
`endif
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [CW:0]          DEPTH_C = FIFO_DEPTH[CW:0];
  localparam logic [SRAM_ADDR_W-1:0] ONE_A = 1;
  localparam logic [PW-1:0]          ONE_P = 1;
  localparam logic [CW-1:0]          ONE_C = 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]             r_state;
  logic [1:0]             w_state_nxt;
  logic [SRAM_ADDR_W-1:0] r_base;
  logic [SRAM_ADDR_W-1:0] r_len;
  logic [SRAM_ADDR_W-1:0] r_issue_off;
  logic [SRAM_ADDR_W-1:0] r_pc;
  logic [CW-1:0]          r_out;
  logic [CW-1:0]          r_count;
  logic [PW-1:0]          r_wr_ptr;
  logic [PW-1:0]          r_rd_ptr;
  logic [INSTR_W-1:0]     r_mem [FIFO_DEPTH];
  logic                   r_end;
  logic                   r_flush;

  logic                   w_start;
  logic                   w_active;
  logic                   w_stop;
  logic                   w_empty;
  logic                   w_ret;
  logic                   w_ret_end;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_credit;
  logic                   w_issue;
  logic [CW:0]            w_inflight;

  assign w_start    = start && (r_state == S_IDLE);
  assign w_active   = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_stop     = stop && w_active;
  assign w_empty    = (r_count == '0);
  // Returns are only meaningful while a program is live; stale ones after reset land in S_IDLE
  assign w_ret      = rd_valid && (r_state != S_IDLE);
  assign w_ret_end  = w_ret && (rd_data[7:0] == isa_pkg::OP_END);
  assign w_push     = w_ret && !w_ret_end && !r_end && !r_flush && !w_stop;
  assign w_inflight = {1'b0, r_count} + {1'b0, r_out};
  assign w_credit   = (w_inflight < DEPTH_C);
  // Issue is also blocked in the very cycle an END word or stop arrives
  assign w_issue    = (r_state == S_RUN) && (r_issue_off < r_len) && !r_end && !r_flush &&
                      !w_stop && !w_ret_end && w_credit;
  assign w_pop      = instr_valid && instr_ready;

  assign rd_en       = w_issue;
  assign rd_addr     = r_base + r_issue_off;
  assign instr_valid = !w_empty && !r_flush;
  assign instr_data  = r_mem[r_rd_ptr];
  assign pc          = r_pc;
  assign done        = (r_state == S_DONE);
  assign busy        = (r_state != S_IDLE);

  // Next-state selection for the fetch sequencer
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_RUN;
      S_RUN:   if (w_stop || w_ret_end || (r_issue_off == r_len)) w_state_nxt = S_DRAIN;
      S_DRAIN: if (!w_stop && (r_out == '0) && w_empty) w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Program context: base, length, issue offset, pc and the end/flush flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base      <= '0;
      r_len       <= '0;
      r_issue_off <= '0;
      r_pc        <= '0;
      r_end       <= 1'b0;
      r_flush     <= 1'b0;
    end else if (w_start) begin
      r_base      <= ucode_base_addr;
      r_len       <= ucode_len;
      r_issue_off <= '0;
      r_pc        <= '0;
      r_end       <= 1'b0;
      r_flush     <= 1'b0;
    end else begin
      if (w_issue)   r_issue_off <= r_issue_off + ONE_A;
      if (w_pop)     r_pc        <= r_pc + ONE_A;
      if (w_ret_end) r_end       <= 1'b1;
      if (w_stop)    r_flush     <= 1'b1;
    end
  end

  // Outstanding SRAM reads: +1 per issue, -1 per return
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= '0;
    end else begin
      case ({w_issue, w_ret})
        2'b10:   r_out <= r_out + ONE_C;
        2'b01:   if (r_out != '0) r_out <= r_out - ONE_C;
        default: r_out <= r_out;
      endcase
    end
  end

  // Queue pointers and fill level; stop empties the queue on the next edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_stop || w_start) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + ONE_P;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + ONE_P;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + ONE_C;
        2'b01:   r_count <= r_count - ONE_C;
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue storage, cleared on reset so instr_data reads zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= rd_data;
    end
  end

`ifdef UCODE_PREFETCH_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_starve;
  logic        w_starve;

  // Starving: queue empty while more words of this program can still arrive
  assign w_starve = w_active && w_empty && !r_end && !r_flush &&
                    ((r_issue_off != r_len) || (r_out != '0));

  // Saturating stall/starve counters, cleared on an accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_stall  <= '0;
      r_perf_starve <= '0;
    end else if (w_start) begin
      r_perf_stall  <= '0;
      r_perf_starve <= '0;
    end else begin
      if (instr_valid && !instr_ready && (r_perf_stall != '1)) r_perf_stall <= r_perf_stall + 32'd1;
      if (w_starve && (r_perf_starve != '1)) r_perf_starve <= r_perf_starve + 32'd1;
    end
  end

  assign perf_stall_cycles  = r_perf_stall;
  assign perf_starve_cycles = r_perf_starve;
`endif

endmodule

// File: tb/tb_ucode_prefetch.sv
// Testbench for ucode_prefetch: table of program runs against an SRAM model
// with configurable latency, plus stop and mid-program reset sequences.
`timescale 1ns/1ps
module tb_ucode_prefetch;
  localparam int unsigned IW = 128;
  localparam int unsigned AW = 12;
  localparam int          FD = 4;

  typedef struct {
    logic [AW-1:0] base;
    logic [AW-1:0] len;
    int            lat;
    int            end_idx;
    int            stall;
    int            exp_issue;
    int            exp_disp;
    int            exp_done_rel;
    logic [AW-1:0] exp_last_addr;
    bit            chk_tput;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [AW-1:0] ucode_base_addr = '0;
  logic [AW-1:0] ucode_len = '0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [IW-1:0] rd_data = '0;
  logic          rd_valid = 1'b0;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [IW-1:0] instr_data;
  logic [AW-1:0] pc;
  logic          done;
  logic          busy;
`ifdef UCODE_PREFETCH_PERF_EN
  logic [31:0]   perf_stall_cycles;
  logic [31:0]   perf_starve_cycles;
`endif

  always #5 clk = ~clk;

  ucode_prefetch #(.INSTR_W(IW), .SRAM_ADDR_W(AW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .ucode_base_addr(ucode_base_addr), .ucode_len(ucode_len),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
    .pc(pc), .done(done), .busy(busy)
`ifdef UCODE_PREFETCH_PERF_EN
    , .perf_stall_cycles(perf_stall_cycles), .perf_starve_cycles(perf_starve_cycles)
`endif
  );

  int            tests = 0;
  int            fails = 0;
  int            cyc = 0;
  int            lat = 1;
  logic [AW-1:0] p_base = '0;
  bit            end_en = 1'b0;
  logic [AW-1:0] end_addr = '0;
  int            pend_due[$];
  logic [AW-1:0] pend_addr[$];
  int n_issue, n_ret, n_kept, n_disp, n_done, max_occ, done_cyc, out_at_done;
  int end_ret_cyc, en_after_end, addr_err, disp_err;
  int first_issue_cyc, first_ret_cyc, first_valid_cyc, first_disp_cyc, last_disp_cyc;
  bit end_seen;
  logic [AW-1:0] last_addr;

  function automatic logic [IW-1:0] word_of(input logic [AW-1:0] a);
    logic [IW-1:0] w;
    w = '0;
    w[IW-1:IW-32] = 32'hFACE_0000 | 32'(a);
    w[47:16]      = 32'(a) * 32'd7919;
    w[7:0]        = (end_en && (a == end_addr)) ? isa_pkg::OP_END : (8'h01 + {2'b00, a[5:0]});
    return w;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic clear_track();
    n_issue = 0; n_ret = 0; n_kept = 0; n_disp = 0; n_done = 0; max_occ = 0;
    done_cyc = -1; out_at_done = -1; end_ret_cyc = -1; en_after_end = 0;
    addr_err = 0; disp_err = 0; first_issue_cyc = -1; first_ret_cyc = -1;
    first_valid_cyc = -1; first_disp_cyc = -1; last_disp_cyc = -1;
    end_seen = 1'b0; last_addr = '0;
  endtask

  // One clock: drive SRAM return, observe outputs mid-cycle, advance to next negedge
  task automatic tick();
    int            occ;
    logic [AW-1:0] ea;
    if (pend_due.size() > 0 && pend_due[0] == cyc) begin
      rd_valid = 1'b1;
      rd_data  = word_of(pend_addr[0]);
    end else begin
      rd_valid = 1'b0;
      rd_data  = '0;
    end
    #1;
    occ = (n_issue - n_ret) + (n_kept - n_disp);
    if (occ > max_occ) max_occ = occ;
    if (rd_valid) begin
      void'(pend_due.pop_front());
      void'(pend_addr.pop_front());
      n_ret++;
      if (first_ret_cyc < 0) first_ret_cyc = cyc;
      if (rd_data[7:0] == isa_pkg::OP_END) begin
        if (!end_seen) end_ret_cyc = cyc;
        end_seen = 1'b1;
      end else if (!end_seen) begin
        n_kept++;
      end
    end
    if (rd_en) begin
      ea = p_base + AW'(n_issue);
      if (rd_addr !== ea) addr_err++;
      if (end_ret_cyc >= 0) en_after_end++;
      pend_due.push_back(cyc + lat);
      pend_addr.push_back(rd_addr);
      if (first_issue_cyc < 0) first_issue_cyc = cyc;
      last_addr = rd_addr;
      n_issue++;
    end
    if (instr_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (instr_valid && instr_ready) begin
      ea = p_base + AW'(n_disp);
      if (pc !== AW'(n_disp) || instr_data !== word_of(ea)) disp_err++;
      if (first_disp_cyc < 0) first_disp_cyc = cyc;
      last_disp_cyc = cyc;
      n_disp++;
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
      out_at_done = n_issue - n_ret;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int t0;
    clear_track();
    p_base = v.base; lat = v.lat;
    end_en = (v.end_idx >= 0);
    end_addr = v.base + AW'(v.end_idx);
    ucode_base_addr = v.base; ucode_len = v.len;
    instr_ready = (v.stall == 0);
    start = 1'b1; t0 = cyc; tick(); start = 1'b0;
    for (int i = 0; i < 500 && n_done == 0; i++) begin
      instr_ready = ((cyc - t0) >= v.stall);
      tick();
    end
    chk($sformatf("v%0d busy_after_done", idx), busy, 0);
    tick(); tick();
    chk($sformatf("v%0d issues", idx), n_issue, v.exp_issue);
    chk($sformatf("v%0d addr_seq_errs", idx), addr_err, 0);
    chk($sformatf("v%0d dispatches", idx), n_disp, v.exp_disp);
    chk($sformatf("v%0d pc_data_errs", idx), disp_err, 0);
    chk($sformatf("v%0d done_pulses", idx), n_done, 1);
    chk($sformatf("v%0d outstanding_at_done", idx), out_at_done, 0);
    chk($sformatf("v%0d credit_ok", idx), max_occ <= FD, 1);
    if (v.exp_done_rel >= 0) chk($sformatf("v%0d done_cycle", idx), done_cyc - t0, v.exp_done_rel);
    if (v.exp_issue > 0) begin
      chk($sformatf("v%0d last_addr", idx), last_addr, v.exp_last_addr);
      chk($sformatf("v%0d first_rd_en_cycle", idx), first_issue_cyc - t0, 1);
    end
    if (v.end_idx >= 0) chk($sformatf("v%0d rd_en_after_end", idx), en_after_end, 0);
    if (v.chk_tput) begin
      chk($sformatf("v%0d dispatch_span", idx), last_disp_cyc - first_disp_cyc, v.exp_disp - 1);
      chk($sformatf("v%0d ret_to_valid", idx), first_valid_cyc - first_ret_cyc, 1);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, " rd_en"}, rd_en, 0);
    chk({tag, " instr_valid"}, instr_valid, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " rd_addr"}, rd_addr, 0);
    chk({tag, " instr_data"}, instr_data, 0);
    chk({tag, " pc"}, pc, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   t0;
    int   bad;
    //          base     len    lat end stall iss disp done last     tput
    vecs[0] = '{12'h100, 12'd3,  1, -1,  0,   3,  3,   7,  12'h102, 1'b1};
    vecs[1] = '{12'h234, 12'd0,  1, -1,  0,   0,  0,   3,  12'h000, 1'b0};
    vecs[2] = '{12'hFFE, 12'd4,  2, -1,  0,   4,  4,  -1,  12'h001, 1'b1};
    vecs[3] = '{12'h040, 12'd8,  3, -1,  10,  8,  8,  -1,  12'h047, 1'b0};
    vecs[4] = '{12'h300, 12'd6,  2,  2,  0,   4,  2,  -1,  12'h303, 1'b0};
    vecs[5] = '{12'h7F0, 12'd16, 2, -1,  0,   16, 16, -1,  12'h7FF, 1'b1};

    @(negedge clk);
    chk_reset_outs("reset");
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // stop with two queued and two outstanding; a start while busy must be ignored
    clear_track();
    p_base = 12'h500; lat = 3; end_en = 1'b0;
    ucode_base_addr = 12'h500; ucode_len = 12'd8; instr_ready = 1'b0;
    start = 1'b1; t0 = cyc; tick(); start = 1'b0;
    for (int i = 1; i < 6; i++) begin
      if (i == 2) begin
        start = 1'b1; ucode_base_addr = 12'hABC; ucode_len = 12'd1;
      end
      tick();
      start = 1'b0;
    end
    chk("stop setup outstanding", n_issue - n_ret, 2);
    chk("stop setup queued", n_kept - n_disp, 2);
    stop = 1'b1; tick(); stop = 1'b0;
    instr_ready = 1'b1;
    chk("stop instr_valid_next", instr_valid, 0);
    chk("stop rd_en_next", rd_en, 0);
    for (int i = 0; i < 100 && n_done == 0; i++) tick();
    chk("stop busy_after_done", busy, 0);
    tick(); tick();
    chk("stop dispatches", n_disp, 0);
    chk("stop issues", n_issue, 4);
    chk("stop addr_seq_errs", addr_err, 0);
    chk("stop done_pulses", n_done, 1);
    chk("stop outstanding_at_done", out_at_done, 0);

    // asynchronous reset mid-program with reads in flight
    clear_track();
    p_base = 12'h020; lat = 3; end_en = 1'b0;
    ucode_base_addr = 12'h020; ucode_len = 12'd8; instr_ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    chk("rst outstanding_before", n_issue - n_ret, 3);
    #2 rst_n = 1'b0;
    #1 chk_reset_outs("midrst");
    tick(); tick();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (instr_valid || busy || rd_en || done) bad++;
    end
    chk("rst stale_returns_ignored", bad, 0);
    chk("rst no_dispatch", n_disp, 0);
    run_vec(vecs[0], 6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
